imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle core's instruction memory. It accepts a byte stream (valid/ready) carrying a length header, little-endian instruction words and an XOR checksum. It writes each assembled word into instruction memory and holds the core in reset until the image is loaded and verified.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_if.sv | 18 +
 rtl/imem_loader_word_packer.sv | 33 +++
 rtl/imem_loader.sv | 127 ++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream (valid/ready) and instruction-memory write-port bundles.
interface byte_stream_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

interface imem_wr_if #(parameter int ADDR_WIDTH = 8);
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_waddr;
    logic [31:0]           imem_wdata;

    modport master (output imem_we, output imem_waddr, output imem_wdata);
    modport slave  (input imem_we, input imem_waddr, input imem_wdata);
endinterface

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer; the full word is presented combinationally
// alongside the 4th byte so the caller can register it on the same edge.
module loader_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_idx,
    input  logic [7:0]  i_byte,
    input  logic        i_acc,
    input  logic        i_clr,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [23:0] r_lo;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_lo <= '0;
        end else if (i_acc) begin
            case (i_idx)
                2'd0:    r_lo[7:0]   <= i_byte;
                2'd1:    r_lo[15:8]  <= i_byte;
                2'd2:    r_lo[23:16] <= i_byte;
                default: r_lo        <= r_lo;
            endcase
        end
    end

    // Lane 3 is never stored: it is only needed on the completing edge.
    assign o_word      = {i_byte, r_lo};
    assign o_word_done = i_acc && (i_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed image into imem; holds the core in reset until verified.
// Accepts one byte per cycle in HDR0..CSUM (ready from state only); write port and status are registered.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    byte_stream_if.slave  rx,
    imem_wr_if.master     imem,
    output logic          core_rst,
    output logic          done,
    output logic          err
);

    localparam logic [CNT_WIDTH:0] MAX_WORDS = {{CNT_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next;
    logic                  w_rdy;
    logic                  w_acc;
    logic [CNT_WIDTH-1:0]  w_cnt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  r_widx;
    logic [1:0]            r_bidx;
    logic [7:0]            r_xor;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [31:0]           r_wdata;
    logic [31:0]           w_word;
    logic                  w_word_done;
    logic                  w_last_word;
    logic                  r_core_rst;
    logic                  r_done;
    logic                  r_err;

    assign w_rdy       = (r_state == ST_HDR0) || (r_state == ST_HDR1) ||
                         (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_acc       = rx.rx_valid && w_rdy;
    assign w_cnt       = {rx.rx_data, r_cnt[7:0]};
    assign w_last_word = (r_widx == (r_cnt - 16'd1));

    loader_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_idx       (r_bidx),
        .i_byte      (rx.rx_data),
        .i_acc       (w_acc && (r_state == ST_DATA)),
        .i_clr       (r_state != ST_DATA),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_HDR0;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HDR0: if (w_acc) w_next = ST_HDR1;
            ST_HDR1: begin
                if (w_acc) begin
                    if ({1'b0, w_cnt} > MAX_WORDS) w_next = ST_ERR;
                    else if (w_cnt == '0)          w_next = ST_CSUM;
                    else                           w_next = ST_DATA;
                end
            end
            ST_DATA: if (w_word_done && w_last_word) w_next = ST_CSUM;
            ST_CSUM: if (w_acc) w_next = (rx.rx_data == r_xor) ? ST_DONE : ST_ERR;
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_widx     <= '0;
            r_bidx     <= '0;
            r_xor      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_acc) r_xor <= r_xor ^ rx.rx_data;
            case (r_state)
                ST_HDR0: if (w_acc) r_cnt[7:0] <= rx.rx_data;
                ST_HDR1: begin
                    if (w_acc) begin
                        r_cnt[15:8] <= rx.rx_data;
                        r_widx      <= '0;
                        r_bidx      <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_acc) r_bidx <= r_bidx + 2'd1;
                    if (w_word_done) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_widx[ADDR_WIDTH-1:0];
                        r_wdata <= w_word;
                        r_widx  <= r_widx + 16'd1;
                    end
                end
                default: ;
            endcase
            // Status follows the next state so it moves on the deciding edge.
            r_done     <= (w_next == ST_DONE);
            r_err      <= (w_next == ST_ERR);
            r_core_rst <= (w_next != ST_DONE);
        end
    end

    assign rx.rx_ready     = w_rdy;
    assign imem.imem_we    = r_we;
    assign imem.imem_waddr = r_waddr;
    assign imem.imem_wdata = r_wdata;
    assign core_rst        = r_core_rst;
    assign done            = r_done;
    assign err             = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: full-rate, bad checksum, overflow, max size, empty image, gaps, mid-load reset.
module tb_imem_loader;

    logic clk;
    logic rst;
    logic core_rst;
    logic done;
    logic err;

    byte_stream_if            s_if ();
    imem_wr_if #(.ADDR_WIDTH(8)) w_if ();

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (s_if),
        .imem     (w_if),
        .core_rst (core_rst),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    logic [7:0]  wr_addr [512];
    logic [31:0] wr_data [512];
    logic [31:0] mem     [256];

    logic [7:0] img1 [11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                              8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};

    always @(posedge clk) begin
        if (w_if.imem_we) begin
            wr_addr[n_wr]        <= w_if.imem_waddr;
            wr_data[n_wr]        <= w_if.imem_wdata;
            mem[w_if.imem_waddr] <= w_if.imem_wdata;
            n_wr                 <= n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        s_if.rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t             = 0;
        s_if.rx_valid = 1'b1;
        s_if.rx_data  = b;
        @(negedge clk);
        while (!s_if.rx_ready && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (!s_if.rx_ready) begin
            chk("rx_ready_wait", 32'(s_if.rx_ready), 32'd1);
            s_if.rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            s_if.rx_valid = 1'b0;
        end
    endtask

    task automatic send_gap(input logic [7:0] b);
        int g;
        g = $urandom_range(0, 1);
        if (g != 0) begin
            @(posedge clk);
            #1;
        end
        send(b);
    endtask

    initial begin
        int          base;
        int          bad;
        logic [7:0]  k;
        logic [31:0] exp_w;

        rst           = 1'b1;
        s_if.rx_valid = 1'b0;
        s_if.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", 32'(s_if.rx_ready), 32'd1);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_we", 32'(w_if.imem_we), 32'd0);
        chk("rst_waddr", 32'(w_if.imem_waddr), 32'd0);
        chk("rst_wdata", w_if.imem_wdata, 32'd0);
        rst = 1'b0;

        // Full-rate two-word image with exact write timing.
        base = n_wr;
        for (int i = 0; i < 6; i++) send(img1[i]);
        chk("t1_we0", 32'(w_if.imem_we), 32'd1);
        chk("t1_addr0", 32'(w_if.imem_waddr), 32'd0);
        chk("t1_data0", w_if.imem_wdata, 32'h0050_0093);
        send(img1[6]);
        chk("t1_we_pulse", 32'(w_if.imem_we), 32'd0);
        for (int i = 7; i < 10; i++) send(img1[i]);
        chk("t1_we1", 32'(w_if.imem_we), 32'd1);
        chk("t1_addr1", 32'(w_if.imem_waddr), 32'd1);
        chk("t1_data1", w_if.imem_wdata, 32'h00A0_0113);
        chk("t1_core_rst_pre", 32'(core_rst), 32'd1);
        send(img1[10]);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_core_rst", 32'(core_rst), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_rx_ready", 32'(s_if.rx_ready), 32'd0);
        chk("t1_nwr", 32'(n_wr - base), 32'd2);
        chk("t1_mem0", mem[0], 32'h0050_0093);
        chk("t1_mem1", mem[1], 32'h00A0_0113);
        s_if.rx_valid = 1'b1;
        s_if.rx_data  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        s_if.rx_valid = 1'b0;
        chk("t1_ignore_nwr", 32'(n_wr - base), 32'd2);
        chk("t1_ignore_done", 32'(done), 32'd1);

        // Checksum off by one.
        do_reset();
        chk("t2_core_rst_after_rst", 32'(core_rst), 32'd1);
        base = n_wr;
        for (int i = 0; i < 10; i++) send(img1[i]);
        send(8'h72);
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_core_rst", 32'(core_rst), 32'd1);
        chk("t2_rx_ready", 32'(s_if.rx_ready), 32'd0);
        chk("t2_nwr", 32'(n_wr - base), 32'd2);

        // Header 257 overflows a 256-word memory.
        do_reset();
        base = n_wr;
        send(8'h01);
        send(8'h01);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_rx_ready", 32'(s_if.rx_ready), 32'd0);
        chk("t3_core_rst", 32'(core_rst), 32'd1);
        chk("t3_nwr", 32'(n_wr - base), 32'd0);

        // Header 256 fills memory; word k = {k, ~k, A5, k}, data XOR cancels so CSUM = 01.
        do_reset();
        base = n_wr;
        send(8'h00);
        send(8'h01);
        chk("t4_err_hdr", 32'(err), 32'd0);
        for (int i = 0; i < 256; i++) begin
            k = 8'(i);
            send(k);
            send(8'hA5);
            send(~k);
            send(k);
        end
        chk("t4_core_rst_pre", 32'(core_rst), 32'd1);
        send(8'h01);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_core_rst", 32'(core_rst), 32'd0);
        chk("t4_nwr", 32'(n_wr - base), 32'd256);
        chk("t4_last_addr", 32'(wr_addr[base + 255]), 32'd255);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            k     = 8'(i);
            exp_w = {k, ~k, 8'hA5, k};
            if (wr_addr[base + i] !== k || wr_data[base + i] !== exp_w) bad++;
        end
        chk("t4_log_bad", 32'(bad), 32'd0);

        // Empty image.
        do_reset();
        base = n_wr;
        send(8'h00);
        send(8'h00);
        chk("t5_done_pre", 32'(done), 32'd0);
        send(8'h00);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_core_rst", 32'(core_rst), 32'd0);
        chk("t5_nwr", 32'(n_wr - base), 32'd0);
        do_reset();
        send(8'h00);
        send(8'h00);
        send(8'h5A);
        chk("t5_bad_err", 32'(err), 32'd1);
        chk("t5_bad_done", 32'(done), 32'd0);

        // Random valid gaps.
        do_reset();
        base = n_wr;
        for (int i = 0; i < 11; i++) send_gap(img1[i]);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_nwr", 32'(n_wr - base), 32'd2);
        chk("t6_addr0", 32'(wr_addr[base]), 32'd0);
        chk("t6_data0", wr_data[base], 32'h0050_0093);
        chk("t6_addr1", 32'(wr_addr[base + 1]), 32'd1);
        chk("t6_data1", wr_data[base + 1], 32'h00A0_0113);

        // Reset after 6 of 8 data bytes, then resend.
        do_reset();
        mem[1] = 32'hDEAD_BEEF;
        base   = n_wr;
        for (int i = 0; i < 8; i++) send(img1[i]);
        chk("t7_nwr_partial", 32'(n_wr - base), 32'd1);
        do_reset();
        chk("t7_we_after_rst", 32'(w_if.imem_we), 32'd0);
        chk("t7_nwr_after_rst", 32'(n_wr - base), 32'd1);
        chk("t7_mem1_untouched", mem[1], 32'hDEAD_BEEF);
        for (int i = 0; i < 11; i++) send(img1[i]);
        chk("t7_nwr", 32'(n_wr - base), 32'd3);
        chk("t7_mem0", mem[0], 32'h0050_0093);
        chk("t7_mem1", mem[1], 32'h00A0_0113);
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_core_rst", 32'(core_rst), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
